// File: rtl/tt_pkg.sv
// tt_pkg: types and constants shared by the times-table reader.
//   - tt_state_t : sweep FSM state encoding
//   - RESP_OKAY  : AXI4-Lite OKAY response code
//   - OP_W       : operand width (a, b)
//   - PROD_W     : product width
package tt_pkg;
  localparam int         OP_W      = 3;
  localparam int         PROD_W    = 6;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_OUT,
    ST_DONE
  } tt_state_t;
endpackage

// File: rtl/tt_index_counter.sv
// tt_index_counter: nested a/b operand counters for the table sweep.
// b is the inner index (0..B_MAX); a is the outer index (0..A_MAX).
// Ports:
//   clk, rst   clock and async active-high reset
//   i_clear    return both counters to 0
//   i_incr     step to the next (a, b) pair
//   o_a, o_b   current operands
//   o_last     current pair is (A_MAX, B_MAX)
module tt_index_counter
  import tt_pkg::*;
#(
  parameter int A_MAX = 7,
  parameter int B_MAX = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_incr,
  output logic [OP_W-1:0] o_a,
  output logic [OP_W-1:0] o_b,
  output logic            o_last
);
  localparam logic [OP_W-1:0] A_LAST = OP_W'(A_MAX);
  localparam logic [OP_W-1:0] B_LAST = OP_W'(B_MAX);

  logic [OP_W-1:0] r_a;
  logic [OP_W-1:0] r_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_clear) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_incr) begin
      if (r_b != B_LAST) begin
        r_b <= r_b + 1'b1;
      end else begin
        r_b <= '0;
        if (r_a != A_LAST) r_a <= r_a + 1'b1;
      end
    end
  end

  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_last = (r_a == A_LAST) && (r_b == B_LAST);
endmodule

// File: rtl/times_table_reader.sv
// times_table_reader: sweeps a times table by reading products from an
// AXI4-Lite multiplier at address {a, b} and streaming (a, b, product)
// entries downstream with a valid/ready handshake.
// Optional build macro: TT_CHECK_EN adds a comparator of rdata against a*b
// and the sticky output check_err.
// Ports:
//   clk, rst                        clock, async active-high reset
//   start                           one-cycle sweep request (IDLE only)
//   arvalid/arready/araddr          AXI4-Lite read address channel
//   rvalid/rready/rdata/rresp       AXI4-Lite read data channel
//   out_valid/out_ready             downstream entry handshake
//   out_a/out_b/out_product         current entry
//   busy, done                      sweep in progress / end-of-sweep pulse
//   resp_err                        sticky non-OKAY response seen
//   check_err (TT_CHECK_EN only)    sticky product mismatch seen
//
// state   | meaning
// IDLE    | waiting for start
// ADDR    | read address presented, waiting for arready
// DATA    | waiting for read data
// OUT     | entry presented downstream, waiting for out_ready
// DONE    | one-cycle done pulse
module times_table_reader
  import tt_pkg::*;
#(
  parameter int A_MAX = 7,
  parameter int B_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              arvalid,
  input  logic              arready,
  output logic [5:0]        araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [5:0]        rdata,
  input  logic [1:0]        rresp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_a,
  output logic [OP_W-1:0]   out_b,
  output logic [PROD_W-1:0] out_product,
  output logic              busy,
  output logic              done,
  output logic              resp_err
`ifdef TT_CHECK_EN
  ,
  output logic              check_err
`endif
);
  tt_state_t         r_state;
  tt_state_t         w_next_state;
  logic              w_clear;
  logic              w_incr;
  logic              w_capture;
  logic [OP_W-1:0]   w_a;
  logic [OP_W-1:0]   w_b;
  logic              w_last;
  logic [OP_W-1:0]   r_out_a;
  logic [OP_W-1:0]   r_out_b;
  logic [PROD_W-1:0] r_out_product;
  logic              r_resp_err;

  tt_index_counter #(
    .A_MAX (A_MAX),
    .B_MAX (B_MAX)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_incr  (w_incr),
    .o_a     (w_a),
    .o_b     (w_b),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_incr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_next_state = ST_ADDR;
        end
      end
      ST_ADDR: if (arready) w_next_state = ST_DATA;
      ST_DATA: if (rvalid)  w_next_state = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          if (w_last) begin
            w_next_state = ST_DONE;
          end else begin
            w_incr       = 1'b1;
            w_next_state = ST_ADDR;
          end
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // rvalid is only looked at in DATA, so data landing alongside the AR
  // handshake is ignored until the following cycle.
  assign w_capture = (r_state == ST_DATA) && rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_a       <= '0;
      r_out_b       <= '0;
      r_out_product <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_a       <= w_a;
        r_out_b       <= w_b;
        r_out_product <= rdata;
      end
      if (w_clear)                              r_resp_err <= 1'b0;
      else if (w_capture && rresp != RESP_OKAY) r_resp_err <= 1'b1;
    end
  end

`ifdef TT_CHECK_EN
  logic [PROD_W-1:0] w_expect;
  logic              r_check_err;

  assign w_expect = PROD_W'(w_a) * PROD_W'(w_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_check_err <= 1'b0;
    else if (w_clear)                        r_check_err <= 1'b0;
    else if (w_capture && rdata != w_expect) r_check_err <= 1'b1;
  end

  assign check_err = r_check_err;
`endif

  assign arvalid     = (r_state == ST_ADDR);
  assign rready      = (r_state == ST_DATA);
  assign out_valid   = (r_state == ST_OUT);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign araddr      = {w_a, w_b};
  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_product = r_out_product;
  assign resp_err    = r_resp_err;
endmodule

// File: tb/tb_times_table_reader.sv
// Bench for times_table_reader: an AXI4-Lite multiplier responder and a
// downstream sink are modelled inside tick(); expected entries are queued
// before each sweep and popped on every downstream handshake.
module tb_times_table_reader;
  logic       clk = 1'b0;
  logic       rst, start, arready, rvalid, out_ready;
  logic [5:0] rdata;
  logic [1:0] rresp;
  logic       arvalid, rready, out_valid, busy, done, resp_err;
  logic [5:0] araddr, out_product;
  logic [2:0] out_a, out_b;
`ifdef TT_CHECK_EN
  logic       check_err;
`endif

  times_table_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_product (out_product),
    .busy        (busy),
    .done        (done),
    .resp_err    (resp_err)
`ifdef TT_CHECK_EN
    ,
    .check_err   (check_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] p;
  } entry_t;

  entry_t     sb[$];
  int         n_cmp = 0;
  int         n_mis = 0;

  bit         pend, ar_hs, r_hs;
  logic [5:0] lat_addr, hs_addr, ar_exp;
  logic [5:0] ar_stall_addr, o_stall_addr, err_addr, force_addr, rst_addr;
  int         ar_stall_left, o_stall_left;
  bit         ar_stalling, o_stalling, err_en, force_en, rst_arm, rst_hit;
  logic [5:0] force_val;
  int         done_cnt;
  logic       resp_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] prod(input logic [5:0] ad);
    return {3'b000, ad[5:3]} * {3'b000, ad[2:0]};
  endfunction

  function automatic logic [31:0] all_outs();
    return {8'h00, arvalid, rready, out_valid, busy, done, resp_err,
            araddr, out_a, out_b, out_product};
  endfunction

  task automatic push_entries(input int last_idx);
    entry_t e;
    logic [5:0] ad;
    for (int i = 0; i <= last_idx; i++) begin
      ad  = 6'(i);
      e.a = ad[5:3];
      e.b = ad[2:0];
      e.p = (force_en && ad == force_addr) ? force_val : prod(ad);
      sb.push_back(e);
    end
  endtask

  // One clock of both peers, evaluated on the falling edge.
  task automatic tick();
    entry_t e;
    @(negedge clk);
    if (rst) begin
      pend = 0; ar_hs = 0; r_hs = 0;
      arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00; out_ready = 1'b1;
    end else begin
      if (ar_hs) begin
        pend     = 1;
        lat_addr = hs_addr;
        ar_exp   = ar_exp + 6'd1;
      end
      if (r_hs) pend = 0;

      arready = 1'b1;
      if (arvalid === 1'b1) chk("araddr", araddr, ar_exp);
      if (!ar_stalling && ar_stall_left > 0 && arvalid === 1'b1 && ar_exp == ar_stall_addr)
        ar_stalling = 1;
      if (ar_stalling) begin
        if (ar_stall_left > 0) begin
          chk("ar_stall_arvalid", arvalid, 1);
          chk("ar_stall_araddr", araddr, ar_stall_addr);
          arready = 1'b0;
          ar_stall_left--;
        end else begin
          ar_stalling = 0;
        end
      end

      rvalid = pend;
      rresp  = (pend && err_en && lat_addr == err_addr) ? 2'b10 : 2'b00;
      rdata  = (force_en && lat_addr == force_addr) ? force_val : prod(lat_addr);
      if (pend && rst_arm && lat_addr == rst_addr) rst_hit = 1;

      out_ready = 1'b1;
      if (!o_stalling && o_stall_left > 0 && out_valid === 1'b1 && sb.size() > 0 &&
          {sb[0].a, sb[0].b} == o_stall_addr)
        o_stalling = 1;
      if (o_stalling) begin
        if (o_stall_left > 0) begin
          chk("out_stall_valid", out_valid, 1);
          chk("out_stall_product", out_product, sb[0].p);
          chk("out_stall_no_done", done, 0);
          out_ready = 1'b0;
          o_stall_left--;
        end else begin
          o_stalling = 0;
        end
      end

      ar_hs   = (arvalid === 1'b1) && arready;
      hs_addr = araddr;
      r_hs    = (rready === 1'b1) && rvalid;
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_mis++;
          $error("FAIL unexpected_entry: observed a=%0d b=%0d p=%0d expected none",
                 out_a, out_b, out_product);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("entry", {out_a, out_b, out_product}, e);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        resp_at_done = resp_err;
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int exp_cycles, input int mid_start);
    int cyc;
    ar_exp   = '0;
    done_cnt = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_resp_err_cleared"}, resp_err, 0);
    while (done_cnt == 0 && cyc < 1000) begin
      tick();
      start = (cyc == mid_start) ? 1'b1 : 1'b0;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, cyc, exp_cycles);
    repeat (4) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_all_entries"}, sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; arready = 1'b1; rvalid = 1'b0; rdata = '0;
    rresp = 2'b00; out_ready = 1'b1;
    pend = 0; ar_hs = 0; r_hs = 0; lat_addr = '0; hs_addr = '0; ar_exp = '0;
    ar_stall_addr = '0; o_stall_addr = '0; err_addr = '0; force_addr = '0;
    rst_addr = '0; force_val = '0; ar_stall_left = 0; o_stall_left = 0;
    ar_stalling = 0; o_stalling = 0; err_en = 0; force_en = 0; rst_arm = 0;
    rst_hit = 0; done_cnt = 0; resp_at_done = 1'b0;

    // reset values
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    tick();

    // nominal sweep: 64 entries, 3 cycles each
    push_entries(63);
    run_sweep("nominal", 193, -1);
    chk("nominal_resp_err", resp_at_done, 0);

    // AR stall on (2,3), R error on (1,1), out stall on (7,7), start while busy
    ar_stall_addr = 6'b010011; ar_stall_left = 5;
    o_stall_addr  = 6'b111111; o_stall_left  = 4;
    err_addr      = 6'b001001; err_en        = 1;
    push_entries(63);
    run_sweep("stalls", 202, 40);
    chk("stalls_resp_err_at_done", resp_at_done, 1);
    chk("stalls_resp_err_sticky", resp_err, 1);
    chk("stalls_ar_stall_used", ar_stall_left, 0);
    chk("stalls_out_stall_used", o_stall_left, 0);
    err_en = 0;

    // reset while in DATA for (4,5)
    push_entries(36);
    rst_addr = 6'b100101; rst_arm = 1; rst_hit = 0;
    ar_exp   = '0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("rst_run_resp_err_cleared", resp_err, 0);
    for (int i = 0; i < 500 && !rst_hit; i++) tick();
    chk("rst_point_reached", rst_hit, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    chk("rst_entries_before", sb.size(), 0);
    rst_arm = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_stays_idle", busy, 0);
    push_entries(63);
    run_sweep("restart", 193, -1);

`ifdef TT_CHECK_EN
    // wrong product on (2,2) with a start while busy
    chk("chk_err_before", check_err, 0);
    force_en = 1; force_addr = 6'b010010; force_val = 6'd5;
    push_entries(63);
    run_sweep("check", 193, 30);
    chk("chk_err_set", check_err, 1);
    force_en = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
